// File: rtl/alu32_rr_scheduler.sv
// Round-robin scheduler sharing one combinational alu32 among NUM_REQ requesters,
// with a single-entry registered response buffer tagged by requester index.
module alu32_rr_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_OPCODE = 15,
  localparam int unsigned IDW       = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*5-1:0]  req_opcode,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [4:0]            alu_opcode,
  input  logic [31:0]           alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_negative,
  input  logic                  alu_carry_out,
  input  logic                  alu_overflow,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [31:0]           rsp_result,
  output logic [3:0]            rsp_flags,
  output logic                  rsp_err,
  output logic [31:0]           issue_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] cand;
  logic           found;
  logic           can_accept;
  logic           xfer;
  logic           illegal;
  logic [IDW-1:0] rsp_id_d;
  logic [31:0]    rsp_result_d;
  logic [3:0]     rsp_flags_d;
  logic           rsp_err_d;
  logic [31:0]    issue_count_d;

  assign rsp_valid = (state_q == FULL);

  // Arbitration, ALU operand mux and next-state/response computation.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant         = '0;
    cand          = '0;
    found         = 1'b0;
    req_ready     = '0;
    alu_a         = '0;
    alu_b         = '0;
    alu_opcode    = '0;
    illegal       = 1'b0;
    rsp_id_d      = rsp_id;
    rsp_result_d  = rsp_result;
    rsp_flags_d   = rsp_flags;
    rsp_err_d     = rsp_err;
    issue_count_d = issue_count;

    can_accept = (state_q == EMPTY) || rsp_ready;

    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((32'(ptr_q) + 32'(k)) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end

    xfer = can_accept && found;

    if (xfer) begin
      req_ready[grant] = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant == IDW'(i)) begin
          alu_a      = req_a[32*i +: 32];
          alu_b      = req_b[32*i +: 32];
          alu_opcode = req_opcode[5*i +: 5];
        end
      end
    end

    illegal = xfer && (alu_opcode > 5'(MAX_OPCODE));

    if (xfer) begin
      state_d  = FULL;
      ptr_d    = IDW'((32'(grant) + 32'd1) % NUM_REQ);
      rsp_id_d = grant;
      // ALU output is undefined for illegal opcodes, so it is never captured.
      rsp_result_d = illegal ? 32'd0 : alu_result;
      rsp_flags_d  = illegal ? 4'd0 : {alu_zero, alu_negative, alu_carry_out, alu_overflow};
      rsp_err_d    = illegal;
      if (issue_count != 32'hFFFF_FFFF) begin
        issue_count_d = issue_count + 32'd1;
      end
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // State and response buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      ptr_q       <= '0;
      rsp_id      <= '0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_err     <= 1'b0;
      issue_count <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_id      <= rsp_id_d;
      rsp_result  <= rsp_result_d;
      rsp_flags   <= rsp_flags_d;
      rsp_err     <= rsp_err_d;
      issue_count <= issue_count_d;
    end
  end

endmodule

// File: tb/tb_alu32_rr_scheduler.sv
// Directed bench for alu32_rr_scheduler with a small behavioural alu32 attached.
module tb_alu32_rr_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDW     = 2;
  localparam int unsigned NVEC    = 10;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ*5-1:0]  req_opcode;
  logic [31:0]           alu_a, alu_b, alu_result;
  logic [4:0]            alu_opcode;
  logic                  alu_zero, alu_negative, alu_carry_out, alu_overflow;
  logic                  rsp_valid, rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_result;
  logic [3:0]            rsp_flags;
  logic                  rsp_err;
  logic [31:0]           issue_count;

  int checks   = 0;
  int failures = 0;

  alu32_rr_scheduler #(.NUM_REQ(NUM_REQ), .MAX_OPCODE(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .issue_count(issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural alu32: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5..15 pass a, >15 garbage.
  logic [32:0] wide;
  always_comb begin
    wide          = '0;
    alu_result    = alu_a;
    alu_carry_out = 1'b0;
    alu_overflow  = 1'b0;
    case (alu_opcode)
      5'd0: begin
        wide          = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result    = wide[31:0];
        alu_carry_out = wide[32];
        alu_overflow  = (alu_a[31] == alu_b[31]) && (wide[31] != alu_a[31]);
      end
      5'd1: begin
        wide          = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_result    = wide[31:0];
        alu_carry_out = wide[32];
        alu_overflow  = (alu_a[31] != alu_b[31]) && (wide[31] != alu_a[31]);
      end
      5'd2: alu_result = alu_a & alu_b;
      5'd3: alu_result = alu_a | alu_b;
      5'd4: alu_result = alu_a ^ alu_b;
      default: if (alu_opcode > 5'd15) begin
        alu_result    = 32'hDEAD_BEEF;
        alu_carry_out = 1'b1;
        alu_overflow  = 1'b1;
      end
    endcase
    alu_zero     = (alu_result == 32'd0);
    alu_negative = alu_result[31];
    if (alu_opcode > 5'd15) begin
      alu_zero     = 1'b1;
      alu_negative = 1'b1;
    end
  end

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [31:0] exp_result;
    logic [3:0]  exp_flags;
    logic        exp_err;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op);
    req_a[32*i +: 32]    = a;
    req_b[32*i +: 32]    = b;
    req_opcode[5*i +: 5] = op;
  endtask

  task automatic set_all_distinct();
    for (int i = 0; i < NUM_REQ; i++) begin
      set_req(i, 32'(256 * (i + 1)), 32'(i), 5'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 4'b1010, 1'b0};
    vecs[1] = '{1, 32'h8000_0000, 32'h0000_0001, 5'd1,  32'h7FFF_FFFF, 4'b0011, 1'b0};
    vecs[2] = '{2, 32'h1234_5678, 32'h0000_0009, 5'd31, 32'h0000_0000, 4'b0000, 1'b1};
    vecs[3] = '{3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd2,  32'h00F0_00F0, 4'b0000, 1'b0};
    vecs[4] = '{3, 32'h0000_0000, 32'h0000_0000, 5'd3,  32'h0000_0000, 4'b1000, 1'b0};
    vecs[5] = '{0, 32'h1234_5678, 32'h1234_5678, 5'd4,  32'h0000_0000, 4'b1000, 1'b0};
    vecs[6] = '{1, 32'h0000_0001, 32'h0000_0002, 5'd16, 32'h0000_0000, 4'b0000, 1'b1};
    vecs[7] = '{2, 32'h8000_0001, 32'h0000_0000, 5'd15, 32'h8000_0001, 4'b0100, 1'b0};
    vecs[8] = '{1, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 4'b0101, 1'b0};
    vecs[9] = '{0, 32'h0000_0005, 32'h0000_0007, 5'd1,  32'hFFFF_FFFE, 4'b0100, 1'b0};

    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_opcode = '0;
    rsp_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check("reset rsp_valid",   32'(rsp_valid), 32'd0);
    check("reset rsp_id",      32'(rsp_id), 32'd0);
    check("reset rsp_result",  rsp_result, 32'd0);
    check("reset rsp_flags",   32'(rsp_flags), 32'd0);
    check("reset rsp_err",     32'(rsp_err), 32'd0);
    check("reset issue_count", issue_count, 32'd0);
    rst_n = 1'b1;

    // Single-requester vectors, response drained every cycle.
    @(negedge clk);
    for (int v = 0; v < NVEC; v++) begin
      req_valid = '0;
      set_req(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].op);
      req_valid[vecs[v].id] = 1'b1;
      #1;
      check($sformatf("vec%0d req_ready", v), 32'(req_ready), 32'(1 << vecs[v].id));
      check($sformatf("vec%0d alu_a", v), alu_a, vecs[v].a);
      check($sformatf("vec%0d alu_opcode", v), 32'(alu_opcode), 32'(vecs[v].op));
      @(negedge clk);
      check($sformatf("vec%0d rsp_valid", v), 32'(rsp_valid), 32'd1);
      check($sformatf("vec%0d rsp_id", v), 32'(rsp_id), 32'(vecs[v].id));
      check($sformatf("vec%0d rsp_result", v), rsp_result, vecs[v].exp_result);
      check($sformatf("vec%0d rsp_flags", v), 32'(rsp_flags), 32'(vecs[v].exp_flags));
      check($sformatf("vec%0d rsp_err", v), 32'(rsp_err), 32'(vecs[v].exp_err));
      check($sformatf("vec%0d issue_count", v), issue_count, 32'(v + 1));
    end
    req_valid = '0;
    #1;
    check("idle alu_a", alu_a, 32'd0);
    @(negedge clk);
    check("drain rsp_valid", 32'(rsp_valid), 32'd0);

    // Backpressure: last grant was req0, so req1 wins next.
    set_all_distinct();
    req_valid = '1;
    rsp_ready = 1'b0;
    #1;
    check("bp first grant", 32'(req_ready), 32'b0010);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp%0d req_ready", c), 32'(req_ready), 32'd0);
      check($sformatf("bp%0d rsp_valid", c), 32'(rsp_valid), 32'd1);
      check($sformatf("bp%0d rsp_id", c), 32'(rsp_id), 32'd1);
      check($sformatf("bp%0d rsp_result", c), rsp_result, 32'h0000_0201);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp release grant", 32'(req_ready), 32'b0100);
    check("bp release old id", 32'(rsp_id), 32'd1);
    @(negedge clk);
    check("bp new rsp_id", 32'(rsp_id), 32'd2);
    check("bp new rsp_result", rsp_result, 32'h0000_0302);

    // Asynchronous reset while holding a response.
    rsp_ready = 1'b0;
    check("pre-reset rsp_valid", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("async reset rsp_id", 32'(rsp_id), 32'd0);
    check("async reset issue_count", issue_count, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '1;
    #1;
    check("post-reset first grant", 32'(req_ready), 32'b0001);

    // Continuous round-robin with no bubbles.
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check($sformatf("rr%0d rsp_valid", j), 32'(rsp_valid), 32'd1);
      check($sformatf("rr%0d rsp_id", j), 32'(rsp_id), 32'(j % 4));
      check($sformatf("rr%0d rsp_result", j), rsp_result, 32'(256 * ((j % 4) + 1) + (j % 4)));
      check($sformatf("rr%0d issue_count", j), issue_count, 32'(j + 1));
    end
    req_valid = '0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
